// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields and zero flag in, datapath enables and selects out.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       ir_we;
   logic       pc_we;
   logic       mem_we;
   logic       WrEn;
   logic [1:0] reg_dst;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_cmd;
   logic [1:0] mem_to_reg;
   logic [1:0] pc_src;
   logic       illegal;
   logic [3:0] state;
   modport master (
      input  opcode, funct, zero,
      output ir_we, pc_we, mem_we, WrEn, reg_dst, alu_src_a, alu_src_b,
             alu_cmd, mem_to_reg, pc_src, illegal, state
   );
   modport slave (
      output opcode, funct, zero,
      input  ir_we, pc_we, mem_we, WrEn, reg_dst, alu_src_a, alu_src_b,
             alu_cmd, mem_to_reg, pc_src, illegal, state
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM of the multicycle CPU, one datapath step per clock.
// Outputs decode from the state register, with illegal and BNE's pc_we also following the inputs.
module multicycle_control (
   input logic                 clk,
   input logic                 reset_n,
   multicycle_control_if.master bus
);
   localparam logic [2:0] CMD_ADD = 3'd0;
   localparam logic [2:0] CMD_SUB = 3'd1;
   localparam logic [2:0] CMD_XOR = 3'd2;
   localparam logic [2:0] CMD_SLT = 3'd3;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic [3:0] {
      S_RST = 4'd0, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BNE, S_JUMP, S_JAL, S_JR
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] r_cmd_q, r_cmd_d;
   logic       is_r, is_jr;

   assign is_r  = bus.opcode == OP_RTYPE &&
                  (bus.funct == FN_ADD || bus.funct == FN_SUB || bus.funct == FN_SLT);
   assign is_jr = bus.opcode == OP_RTYPE && bus.funct == FN_JR;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_RST;
         r_cmd_q <= CMD_ADD;
      end else begin
         state_q <= state_d;
         r_cmd_q <= r_cmd_d;
      end
   end

   always_comb begin
      state_d        = S_FETCH;
      r_cmd_d        = r_cmd_q;
      bus.ir_we      = 1'b0;
      bus.pc_we      = 1'b0;
      bus.mem_we     = 1'b0;
      bus.WrEn       = 1'b0;
      bus.reg_dst    = 2'b00;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_cmd    = CMD_ADD;
      bus.mem_to_reg = 2'b00;
      bus.pc_src     = 2'b00;
      bus.illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.ir_we     = 1'b1;
            bus.pc_we     = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = S_DECODE;
         end
         S_DECODE: begin
            r_cmd_d = bus.funct == FN_SUB ? CMD_SUB : bus.funct == FN_SLT ? CMD_SLT : CMD_ADD;
            state_d = is_r                                       ? S_EXEC_R   :
                      is_jr                                      ? S_JR       :
                      bus.opcode == OP_XORI                      ? S_EXEC_I   :
                      (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEM_ADDR :
                      bus.opcode == OP_BNE                       ? S_BNE      :
                      bus.opcode == OP_J                         ? S_JUMP     :
                      bus.opcode == OP_JAL                       ? S_JAL      : S_FETCH;
            bus.illegal = state_d == S_FETCH;
         end
         S_EXEC_R, S_WB_R: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.alu_cmd   = r_cmd_q;
            bus.WrEn      = state_q == S_WB_R;
            state_d       = state_q == S_EXEC_R ? S_WB_R : S_FETCH;
         end
         S_EXEC_I, S_WB_I: begin
            bus.alu_src_a = 1'b1;
            bus.alu_cmd   = CMD_XOR;
            bus.WrEn      = state_q == S_WB_I;
            bus.reg_dst   = state_q == S_WB_I ? 2'b01 : 2'b00;
            state_d       = state_q == S_EXEC_I ? S_WB_I : S_FETCH;
         end
         // ALU keeps computing the address through the whole memory access
         S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR: begin
            bus.alu_src_a  = 1'b1;
            bus.WrEn       = state_q == S_MEM_WB;
            bus.reg_dst    = state_q == S_MEM_WB ? 2'b01 : 2'b00;
            bus.mem_to_reg = state_q == S_MEM_WB ? 2'b01 : 2'b00;
            bus.mem_we     = state_q == S_MEM_WR;
            state_d        = state_q == S_MEM_ADDR ? (bus.opcode == OP_LW ? S_MEM_RD : S_MEM_WR) :
                             state_q == S_MEM_RD   ? S_MEM_WB : S_FETCH;
         end
         S_BNE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.alu_cmd   = CMD_SUB;
            bus.pc_src    = 2'b01;
            bus.pc_we     = ~bus.zero;
         end
         S_JUMP: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'b10;
         end
         S_JAL: begin
            bus.pc_we      = 1'b1;
            bus.pc_src     = 2'b10;
            bus.WrEn       = 1'b1;
            bus.reg_dst    = 2'b10;
            bus.mem_to_reg = 2'b10;
         end
         S_JR: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'b11;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign bus.state = state_q;
endmodule
